// File: rtl/wb_commit_queue.sv
// Write-back commit queue: turns each accepted instruction into 0..2 register writes, drained in order
// through one registered write port. Optional forwarding search is enabled with WBQ_FWD_EN.
module wb_commit_queue #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 4,
    parameter int PC_REG   = 15,
    parameter int LINK_REG = 14
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic                         i_cond_pass,
    input  logic                         i_branch,
    input  logic                         i_branch_link,
    input  logic                         i_is_load,
    input  logic                         i_is_dp,
    input  logic                         i_base_wb,
    input  logic [REG_AW-1:0]            i_rd,
    input  logic [REG_AW-1:0]            i_rn,
    input  logic [DATA_W-1:0]            i_alu_out,
    input  logic [DATA_W-1:0]            i_dmem_out,
    input  logic [DATA_W-1:0]            i_wb_addr,
    input  logic [DATA_W-1:0]            i_pc,
    input  logic [1:0]                   i_pc_adj,
    input  logic [DATA_W-1:0]            i_b_offset,
`ifdef WBQ_FWD_EN
    input  logic [REG_AW-1:0]            i_fwd_reg,
    output logic                         o_fwd_hit,
    output logic [DATA_W-1:0]            o_fwd_data,
`endif
    output logic                         o_wr_en,
    output logic [REG_AW-1:0]            o_wr_reg,
    output logic [DATA_W-1:0]            o_wr_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_q_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [REG_AW-1:0] PC_IDX   = REG_AW'(PC_REG);
    localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);

    logic [REG_AW-1:0] r_q_reg  [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_wr_en;
    logic [REG_AW-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_ready;
    logic              w_accept;
    logic              w_p_vld;
    logic [REG_AW-1:0] w_p_reg;
    logic [DATA_W-1:0] w_p_data;
    logic              w_s_vld;
    logic [REG_AW-1:0] w_s_reg;
    logic [DATA_W-1:0] w_s_data;
    logic              w_vld0;
    logic              w_vld1;
    logic [REG_AW-1:0] w_reg0;
    logic [DATA_W-1:0] w_data0;
    logic [1:0]        w_npush;
    logic              w_pop;

    // Two free slots are required even for single-entry ops, so entry count never gates acceptance.
    assign w_ready  = (DEPTH_C - r_count) >= CW'(2);
    assign w_accept = i_in_valid & w_ready & i_cond_pass;

    always_comb begin
        w_p_vld  = 1'b0;
        w_p_reg  = i_rd;
        w_p_data = i_alu_out;
        if (i_branch) begin
            w_p_vld  = w_accept;
            w_p_reg  = PC_IDX;
            w_p_data = i_pc - DATA_W'(i_pc_adj) + i_b_offset;
        end else if (i_is_load) begin
            w_p_vld  = w_accept;
            w_p_data = i_dmem_out;
        end else if (i_is_dp) begin
            w_p_vld  = w_accept;
        end
    end

    always_comb begin
        w_s_vld  = 1'b0;
        w_s_reg  = i_rn;
        w_s_data = i_wb_addr;
        if (i_branch && i_branch_link) begin
            w_s_vld  = w_accept;
            w_s_reg  = LINK_IDX;
            w_s_data = i_pc & ~DATA_W'(3);
        end else if (i_base_wb && (i_rn != PC_IDX)) begin
            w_s_vld  = w_accept;
        end
    end

    // A lone secondary entry takes the first slot so pushes stay contiguous.
    assign w_vld0  = w_p_vld | w_s_vld;
    assign w_vld1  = w_p_vld & w_s_vld;
    assign w_reg0  = w_p_vld ? w_p_reg  : w_s_reg;
    assign w_data0 = w_p_vld ? w_p_data : w_s_data;
    assign w_npush = {1'b0, w_p_vld} + {1'b0, w_s_vld};
    assign w_pop   = (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_vld0) begin
            r_q_reg[r_wptr]  <= w_reg0;
            r_q_data[r_wptr] <= w_data0;
        end
        if (w_vld1) begin
            r_q_reg[r_wptr + AW'(1)]  <= w_s_reg;
            r_q_data[r_wptr + AW'(1)] <= w_s_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_npush);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_npush) - CW'(w_pop);
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_reg  <= r_q_reg[r_rptr];
                r_wr_data <= r_q_data[r_rptr];
            end
        end
    end

`ifdef WBQ_FWD_EN
    // Scan oldest to youngest so the last match wins; the head being popped is still visible.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_q_reg[r_rptr + AW'(i)] == i_fwd_reg)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_q_data[r_rptr + AW'(i)];
            end
        end
    end
`endif

    assign o_in_ready = w_ready;
    assign o_wr_en    = r_wr_en;
    assign o_wr_reg   = r_wr_reg;
    assign o_wr_data  = r_wr_data;
    assign o_q_count  = r_count;
endmodule
